// File: rtl/rr_arb_mux.sv
// N-channel registered mux with valid/ready handshake.
// Mode 0 arbitrates round-robin across channels; mode 1 serves the channel named by i_sel.
module rr_arb_mux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 8,
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_mode,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic [NUM_CH*WIDTH-1:0] i_in_data,
  input  logic [NUM_CH-1:0]       i_in_valid,
  output logic [NUM_CH-1:0]       o_in_ready,
  output logic [WIDTH-1:0]        o_out_data,
  output logic [SEL_W-1:0]        o_out_sel,
  output logic                    o_out_valid,
  input  logic                    i_out_ready
);

  localparam logic [SEL_W:0] NumChW = (SEL_W+1)'(NUM_CH);

  logic [SEL_W-1:0]    r_ptr;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_sel;
  logic                r_valid;

  logic                w_load_ok;
  logic                w_found;
  logic [SEL_W-1:0]    w_gidx;
  logic [NUM_CH-1:0]   w_grant;
  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [SEL_W:0]      w_sum;
  logic                w_xfer;
  logic [WIDTH-1:0]    w_gdata;

  assign w_load_ok = !r_valid || i_out_ready;

  // Rotate valids so bit 0 is the channel at r_ptr; first set bit wins.
  assign w_dbl = {i_in_valid, i_in_valid} >> r_ptr;
  assign w_rot = w_dbl[NUM_CH-1:0];

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    if (i_mode) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (i_in_valid[i] && (i_sel == SEL_W'(i))) begin
          w_found = 1'b1;
          w_gidx  = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (!w_found && w_rot[k]) begin
          w_found = 1'b1;
          w_sum   = {1'b0, r_ptr} + (SEL_W+1)'(k);
          if (w_sum >= NumChW) begin
            w_sum = w_sum - NumChW;
          end
          w_gidx = w_sum[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    w_grant = '0;
    w_gdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_found && (w_gidx == SEL_W'(i))) begin
        w_grant[i] = 1'b1;
        w_gdata    = i_in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign o_in_ready = {NUM_CH{i_rst_n && w_load_ok}} & w_grant;
  assign w_xfer     = |(o_in_ready & i_in_valid);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_gdata;
      r_sel   <= w_gidx;
      if (!i_mode) begin
        r_ptr <= (w_gidx == SEL_W'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
      end
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_sel   = r_sel;
  assign o_out_valid = r_valid;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-channel instance for round-robin/backpressure/reset
// and a 3-channel instance for fixed select including an out-of-range sel.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 4-channel instance
  logic        mode4, oready4;
  logic [1:0]  sel4;
  logic [31:0] data4;
  logic [3:0]  valid4, iready4;
  logic [7:0]  odata4;
  logic [1:0]  osel4;
  logic        ovalid4;

  // 3-channel instance
  logic        mode3, oready3;
  logic [1:0]  sel3;
  logic [23:0] data3;
  logic [2:0]  valid3, iready3;
  logic [7:0]  odata3;
  logic [1:0]  osel3;
  logic        ovalid3;

  rr_arb_mux #(.NUM_CH(4), .WIDTH(8)) u_dut4 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode4),
    .i_sel       (sel4),
    .i_in_data   (data4),
    .i_in_valid  (valid4),
    .o_in_ready  (iready4),
    .o_out_data  (odata4),
    .o_out_sel   (osel4),
    .o_out_valid (ovalid4),
    .i_out_ready (oready4)
  );

  rr_arb_mux #(.NUM_CH(3), .WIDTH(8)) u_dut3 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode3),
    .i_sel       (sel3),
    .i_in_data   (data3),
    .i_in_valid  (valid3),
    .o_in_ready  (iready3),
    .o_out_data  (odata3),
    .o_out_sel   (osel3),
    .o_out_valid (ovalid3),
    .i_out_ready (oready3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    mode4   = 1'b0;
    sel4    = 2'd0;
    data4   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    valid4  = 4'b1111;
    oready4 = 1'b1;
    mode3   = 1'b0;
    sel3    = 2'd0;
    data3   = {8'h52, 8'h51, 8'h50};
    valid3  = 3'b000;
    oready3 = 1'b1;

    // Reset held two cycles with all channels valid
    @(posedge clk);
    cyc();
    check_eq("rst_iready", 32'(iready4), 32'h0);
    check_eq("rst_ovalid", 32'(ovalid4), 32'h0);
    check_eq("rst_odata",  32'(odata4),  32'h0);
    check_eq("rst_osel",   32'(osel4),   32'h0);

    // Round-robin, all valid, one word per cycle
    rst_n = 1'b1;
    #1;
    check_eq("rr_first_ready", 32'(iready4), 32'b0001);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check_eq("rr_sel",   32'(osel4),   32'(k % 4));
      check_eq("rr_data",  32'(odata4),  32'(8'hA0 + k % 4));
      check_eq("rr_valid", 32'(ovalid4), 32'h1);
    end

    // Backpressure: held word stable, no grants
    oready4 = 1'b0;
    #1;
    check_eq("bp_ready_now", 32'(iready4), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("bp_sel",   32'(osel4),   32'h0);
      check_eq("bp_data",  32'(odata4),  32'hA0);
      check_eq("bp_valid", 32'(ovalid4), 32'h1);
      check_eq("bp_ready", 32'(iready4), 32'h0);
    end
    oready4 = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(iready4), 32'b0010);
    cyc();
    check_eq("bp_next_sel",  32'(osel4),  32'h1);
    check_eq("bp_next_data", 32'(odata4), 32'hA1);

    // Wrap then sparse: ch2, ch3, then only ch2 valid
    cyc();
    check_eq("wr_sel2", 32'(osel4), 32'h2);
    cyc();
    check_eq("wr_sel3",  32'(osel4),  32'h3);
    check_eq("wr_data3", 32'(odata4), 32'hA3);
    valid4 = 4'b0100;
    #1;
    check_eq("sp_ready", 32'(iready4), 32'b0100);
    cyc();
    check_eq("sp_sel",  32'(osel4),  32'h2);
    check_eq("sp_data", 32'(odata4), 32'hA2);
    valid4 = 4'b1111;
    #1;
    check_eq("sp_ptr3", 32'(iready4), 32'b1000);
    cyc();
    check_eq("sp_sel3", 32'(osel4), 32'h3);

    // No valid channels: output drains, last word held
    valid4 = 4'b0000;
    #1;
    check_eq("idle_ready", 32'(iready4), 32'h0);
    cyc();
    check_eq("idle_valid", 32'(ovalid4), 32'h0);
    check_eq("idle_data",  32'(odata4),  32'hA3);
    check_eq("idle_sel",   32'(osel4),   32'h3);

    // Reset while stalled: held word discarded, pointer back to 0
    valid4  = 4'b1111;
    oready4 = 1'b0;
    cyc();
    check_eq("mr_loaded", 32'(osel4), 32'h0);
    check_eq("mr_stall_ready", 32'(iready4), 32'h0);
    rst_n   = 1'b0;
    oready4 = 1'b1;
    #1;
    check_eq("mr_rst_ready", 32'(iready4), 32'h0);
    cyc();
    check_eq("mr_valid", 32'(ovalid4), 32'h0);
    check_eq("mr_data",  32'(odata4),  32'h0);
    rst_n  = 1'b1;
    valid4 = 4'b1011;
    #1;
    check_eq("mr_first_ready", 32'(iready4), 32'b0001);
    cyc();
    check_eq("mr_first_sel",  32'(osel4),  32'h0);
    check_eq("mr_first_data", 32'(odata4), 32'hA0);
    valid4 = 4'b0000;

    // Fixed select on the 3-channel instance
    mode3  = 1'b1;
    sel3   = 2'd1;
    valid3 = 3'b111;
    #1;
    check_eq("fx_ready", 32'(iready3), 32'b010);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("fx_sel",   32'(osel3),   32'h1);
      check_eq("fx_data",  32'(odata3),  32'h51);
      check_eq("fx_valid", 32'(ovalid3), 32'h1);
      check_eq("fx_ready_loop", 32'(iready3), 32'b010);
    end
    sel3 = 2'd3;
    #1;
    check_eq("fx_oor_ready", 32'(iready3), 32'h0);
    cyc();
    check_eq("fx_oor_valid", 32'(ovalid3), 32'h0);
    check_eq("fx_oor_data",  32'(odata3),  32'h51);
    // Fixed mode must not have advanced the rr pointer
    mode3 = 1'b0;
    #1;
    check_eq("fx_to_rr_ready", 32'(iready3), 32'b001);
    cyc();
    check_eq("fx_to_rr_sel",  32'(osel3),  32'h0);
    check_eq("fx_to_rr_data", 32'(odata3), 32'h50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
